// File: rtl/n_bit_counter_pkg.sv
// rtl/n_bit_counter_pkg.sv - shared state type and defaults for the N-bit counter family
package n_bit_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } cnt_state_t;

    localparam int N_DEFAULT = 3;

endpackage

// File: rtl/n_bit_subtractor.sv
// rtl/n_bit_subtractor.sv - combinational ripple-borrow subtractor (DIFF = X - Y, BOUT = X < Y)
module n_bit_subtractor #(
    parameter int N = 3
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] DIFF,
    output logic         BOUT
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    // One full subtractor per bit; the borrow ripples from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_fs
        assign DIFF[i]     = X[i] ^ Y[i] ^ borrow[i];
        assign borrow[i+1] = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & borrow[i]);
    end

    assign BOUT = borrow[N];

endmodule

// File: rtl/n_bit_down_counter.sv
// rtl/n_bit_down_counter.sv - loadable N-bit down counter with borrow/done flags; DOWN_COUNTER_SATURATE_EN clamps on underflow
module n_bit_down_counter
    import n_bit_counter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         LOAD,
    input  logic [N-1:0] D,
    input  logic         EN,
    input  logic [N-1:0] A,
    output logic [N-1:0] F,
    output logic         BOUT,
    output logic         BUSY,
    output logic         DONE
);

    cnt_state_t   state_q;
    cnt_state_t   state_d;
    logic [N-1:0] f_q;
    logic [N-1:0] f_d;
    logic         bout_q;
    logic         bout_d;
    logic [N-1:0] diff;
    logic         borrow;

    n_bit_subtractor #(.N(N)) u_sub (
        .X    (f_q),
        .Y    (A),
        .DIFF (diff),
        .BOUT (borrow)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= n_bit_counter_pkg::IDLE;
            f_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        bout_d  = 1'b0;
        if (LOAD) begin
            f_d     = D;
            state_d = (D != '0) ? n_bit_counter_pkg::COUNT : n_bit_counter_pkg::DONE;
        end else if (state_q == n_bit_counter_pkg::COUNT && EN) begin
            bout_d = borrow;
`ifdef DOWN_COUNTER_SATURATE_EN
            if (borrow) begin
                f_d     = '0;
                state_d = n_bit_counter_pkg::DONE;
            end else begin
                f_d     = diff;
                state_d = (diff == '0) ? n_bit_counter_pkg::DONE : n_bit_counter_pkg::COUNT;
            end
`else
            // Underflow wraps modulo 2^N and keeps counting unless it lands on zero.
            f_d     = diff;
            state_d = (diff == '0) ? n_bit_counter_pkg::DONE : n_bit_counter_pkg::COUNT;
`endif
        end
    end

    always_comb begin
        F    = f_q;
        BOUT = bout_q;
        BUSY = (state_q == n_bit_counter_pkg::COUNT);
        DONE = (state_q == n_bit_counter_pkg::DONE);
    end

endmodule

// File: tb/tb_n_bit_down_counter.sv
// tb/tb_n_bit_down_counter.sv - self-checking bench for n_bit_down_counter (N=3)
module tb_n_bit_down_counter;

    localparam int N = 3;
    localparam int MOD = 1 << N;

    logic         CLK = 1'b0;
    logic         CLR = 1'b0;
    logic         LOAD = 1'b0;
    logic [N-1:0] D = '0;
    logic         EN = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] F;
    logic         BOUT;
    logic         BUSY;
    logic         DONE;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Model: count value, last-step borrow, phase 0=idle 1=counting 2=finished
    int m_f = 0;
    int m_b = 0;
    int m_ph = 0;

    n_bit_down_counter #(.N(N)) dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .LOAD (LOAD),
        .D    (D),
        .EN   (EN),
        .A    (A),
        .F    (F),
        .BOUT (BOUT),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (CLR) begin
            m_f = 0; m_b = 0; m_ph = 0;
        end else if (LOAD) begin
            m_f = int'(D); m_b = 0;
            m_ph = (D != 0) ? 1 : 2;
        end else if (m_ph == 1 && EN) begin
            if (int'(A) > m_f) begin
                m_b = 1;
`ifdef DOWN_COUNTER_SATURATE_EN
                m_f = 0;
`else
                m_f = (m_f - int'(A) + MOD) % MOD;
`endif
            end else begin
                m_b = 0;
                m_f = m_f - int'(A);
            end
            if (m_f == 0) m_ph = 2;
        end else begin
            m_b = 0;
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            check("model_F", int'(F), m_f);
            check("model_BOUT", int'(BOUT), m_b);
            check("model_BUSY", int'(BUSY), (m_ph == 1) ? 1 : 0);
            check("model_DONE", int'(DONE), (m_ph == 2) ? 1 : 0);
        end
    end

    task automatic cyc(input bit clr, input bit load, input int d, input bit en, input int a);
        CLR = clr; LOAD = load; D = N'(d); EN = en; A = N'(a);
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string tag, input int f, input int b, input int busy, input int done);
        check({tag, "_F"}, int'(F), f);
        check({tag, "_BOUT"}, int'(BOUT), b);
        check({tag, "_BUSY"}, int'(BUSY), busy);
        check({tag, "_DONE"}, int'(DONE), done);
        check({tag, "_model_F"}, m_f, f);
    endtask

    initial begin
        // 1. reset, and reset dominating LOAD
        cyc(1, 0, 0, 0, 0);
        checking = 1'b1;
        lit("reset", 0, 0, 0, 0);
        cyc(1, 1, 7, 1, 1);
        lit("reset_load", 0, 0, 0, 0);

        // 2. load 7, count down by 1 to zero
        cyc(0, 1, 7, 0, 0);
        lit("load7", 7, 0, 1, 0);
        for (int i = 6; i >= 0; i--) begin
            cyc(0, 0, 0, 1, 1);
            lit("dec1", i, 0, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0);
        end

        // 3. load 5, step 2 until underflow
        cyc(0, 1, 5, 1, 2);
        lit("load5", 5, 0, 1, 0);
        cyc(0, 0, 0, 1, 2);
        lit("step2_a", 3, 0, 1, 0);
        cyc(0, 0, 0, 1, 2);
        lit("step2_b", 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 2);
`ifdef DOWN_COUNTER_SATURATE_EN
        lit("underflow", 0, 1, 0, 1);
`else
        lit("underflow", 7, 1, 1, 0);
`endif
        cyc(0, 0, 0, 0, 2);
`ifdef DOWN_COUNTER_SATURATE_EN
        lit("after_uf", 0, 0, 0, 1);
`else
        lit("after_uf", 7, 0, 1, 0);
`endif

        // 4. LOAD beats EN, then EN low holds
        cyc(0, 1, 4, 0, 1);
        lit("load4", 4, 0, 1, 0);
        cyc(0, 1, 6, 1, 1);
        lit("reload6", 6, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            lit("hold", 6, 0, 1, 0);
        end

        // A == 0 while counting leaves the count alone
        cyc(0, 0, 0, 1, 0);
        lit("a_zero", 6, 0, 1, 0);

        // 5. CLR mid-count, EN afterwards has no effect
        cyc(0, 1, 5, 0, 1);
        lit("load5b", 5, 0, 1, 0);
        cyc(1, 0, 0, 1, 1);
        lit("clr_mid", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1);
            lit("idle_en", 0, 0, 0, 0);
        end

        // 6. LOAD 0 goes straight to DONE and stays there
        cyc(0, 1, 0, 0, 0);
        lit("load0", 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 3);
        lit("done_en", 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 3);
        lit("done_en2", 0, 0, 0, 1);

        // large step from a small count
        cyc(0, 1, 2, 0, 0);
        lit("load2", 2, 0, 1, 0);
        cyc(0, 0, 0, 1, 7);
`ifdef DOWN_COUNTER_SATURATE_EN
        lit("big_step", 0, 1, 0, 1);
`else
        lit("big_step", 3, 1, 1, 0);
`endif

        cyc(0, 0, 0, 0, 0);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
